// File: rtl/dual_port_mem_arbiter.sv
// Round-robin arbiter sharing one dual-port memory (write port + registered read port) between two requesters.
// Optional same-cycle write-to-read forwarding is enabled by defining DPM_ARB_FWD_EN.
module dual_port_mem_arbiter #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_0,
  input  logic                 req_write_0,
  input  logic [AddrWidth-1:0] req_addr_0,
  input  logic [DataWidth-1:0] req_wdata_0,
  input  logic                 req_valid_1,
  input  logic                 req_write_1,
  input  logic [AddrWidth-1:0] req_addr_1,
  input  logic [DataWidth-1:0] req_wdata_1,
  output logic                 req_ready_0,
  output logic                 req_ready_1,
  output logic                 rsp_valid_0,
  output logic                 rsp_valid_1,
  output logic [DataWidth-1:0] rsp_data_0,
  output logic [DataWidth-1:0] rsp_data_1,
  output logic                 mem_w_enable,
  output logic [AddrWidth-1:0] mem_w_addr,
  output logic [DataWidth-1:0] mem_w_data,
  output logic [AddrWidth-1:0] mem_r_addr,
  input  logic [DataWidth-1:0] mem_r_data
);

  logic wptr, rptr;
  logic wv0, wv1, rv0, rv1;
  logic wg0, wg1, rg0, rg1;
  logic tag_valid, tag_id;
  logic [DataWidth-1:0] rd_sel;

  assign wv0 = req_valid_0 & req_write_0;
  assign wv1 = req_valid_1 & req_write_1;
  assign rv0 = req_valid_0 & ~req_write_0;
  assign rv1 = req_valid_1 & ~req_write_1;

  // On a tie the pointer names the winner; a lone requester always wins.
  assign wg0 = wv0 & (~wv1 | ~wptr);
  assign wg1 = wv1 & (~wv0 | wptr);
  assign rg0 = rv0 & (~rv1 | ~rptr);
  assign rg1 = rv1 & (~rv0 | rptr);

  assign req_ready_0 = wg0 | rg0;
  assign req_ready_1 = wg1 | rg1;

  always_comb begin
    mem_w_enable = 1'b0;
    mem_w_addr   = '0;
    mem_w_data   = '0;
    mem_r_addr   = '0;
    if (wg0) begin
      mem_w_enable = 1'b1;
      mem_w_addr   = req_addr_0;
      mem_w_data   = req_wdata_0;
    end else if (wg1) begin
      mem_w_enable = 1'b1;
      mem_w_addr   = req_addr_1;
      mem_w_data   = req_wdata_1;
    end
    if (rg0) begin
      mem_r_addr = req_addr_0;
    end else if (rg1) begin
      mem_r_addr = req_addr_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      tag_valid <= 1'b0;
      tag_id    <= 1'b0;
    end else begin
      if (wg0) begin
        wptr <= 1'b1;
      end else if (wg1) begin
        wptr <= 1'b0;
      end
      if (rg0) begin
        rptr <= 1'b1;
      end else if (rg1) begin
        rptr <= 1'b0;
      end
      tag_valid <= rg0 | rg1;
      tag_id    <= rg1;
    end
  end

`ifdef DPM_ARB_FWD_EN
  logic                 fwd_flag;
  logic [DataWidth-1:0] fwd_data;

  // The memory returns pre-write contents on a same-address collision, so capture the write data instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_flag <= 1'b0;
      fwd_data <= '0;
    end else begin
      fwd_flag <= (rg0 | rg1) & mem_w_enable & (mem_w_addr == mem_r_addr);
      fwd_data <= mem_w_data;
    end
  end

  assign rd_sel = fwd_flag ? fwd_data : mem_r_data;
`else
  assign rd_sel = mem_r_data;
`endif

  assign rsp_valid_0 = tag_valid & ~tag_id;
  assign rsp_valid_1 = tag_valid & tag_id;
  assign rsp_data_0  = rsp_valid_0 ? rd_sel : '0;
  assign rsp_data_1  = rsp_valid_1 ? rd_sel : '0;

endmodule
